pipe_divider: RTL

PIPE_DIVIDER -- requirements
Module: pipe_divider

---
 rtl/pipe_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_divider.sv
// Multi-cycle radix-2 restoring divider for the EX stage: 32 iterations on operand magnitudes,
// sign fix-up on the last step, divide-by-zero and flush handling, one-cycle done strobe.
module pipe_divider #(
  parameter int DIV_W = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_div_ena,
  input  logic             in_div_sign,
  input  logic [DIV_W-1:0] in_dividend,
  input  logic [DIV_W-1:0] in_divisor,
  input  logic             in_flush,
  output logic             out_busy,
  output logic             out_done,
  output logic [DIV_W-1:0] out_quotient,
  output logic [DIV_W-1:0] out_remainder
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [4:0] LAST_ITER = 5'(DIV_W - 1);

  state_t           state, state_next;
  logic [4:0]       cnt;
  logic [DIV_W-1:0] quo;       // dividend magnitude shifting out, quotient bits shifting in
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] raw_dividend;
  logic             neg_q, neg_r, div_zero;

  logic             start;
  logic             sgn_a, sgn_b;
  logic [DIV_W:0]   shifted, trial;
  logic [DIV_W-1:0] rem_step, quo_step;
  logic [DIV_W-1:0] quo_final, rem_final;

  assign start = (state == IDLE) && in_div_ena && !in_flush;
  assign sgn_a = in_div_sign & in_dividend[DIV_W-1];
  assign sgn_b = in_div_sign & in_divisor[DIV_W-1];

  // One restoring step: keep the trial subtraction only when it did not go negative.
  always_comb begin
    shifted  = {rem, quo[DIV_W-1]};
    trial    = shifted - {1'b0, dvs};
    rem_step = shifted[DIV_W-1:0];
    quo_step = {quo[DIV_W-2:0], 1'b0};
    if (!trial[DIV_W]) begin
      rem_step = trial[DIV_W-1:0];
      quo_step = {quo[DIV_W-2:0], 1'b1};
    end
  end

  // Zero divisor bypasses the sign fix-up so the raw dividend reaches HI untouched.
  always_comb begin
    quo_final = neg_q ? (~quo_step + 1'b1) : quo_step;
    rem_final = neg_r ? (~rem_step + 1'b1) : rem_step;
    if (div_zero) begin
      quo_final = '1;
      rem_final = raw_dividend;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == LAST_ITER) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (in_flush) state_next = IDLE;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      raw_dividend  <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (start) begin
      cnt          <= '0;
      quo          <= sgn_a ? (~in_dividend + 1'b1) : in_dividend;
      dvs          <= sgn_b ? (~in_divisor + 1'b1) : in_divisor;
      rem          <= '0;
      raw_dividend <= in_dividend;
      neg_q        <= sgn_a ^ sgn_b;
      neg_r        <= sgn_a;
      div_zero     <= (in_divisor == '0);
    end else if (state == BUSY && !in_flush) begin
      cnt <= cnt + 5'd1;
      quo <= quo_step;
      rem <= rem_step;
      if (cnt == LAST_ITER) begin
        out_quotient  <= quo_final;
        out_remainder <= rem_final;
      end
    end
  end

  assign out_done = (state == DONE);
  assign out_busy = in_rst_n && ((state == BUSY) || start);

endmodule
